// File: rtl/pack_16i_256o_prefetch.sv
// Narrow-to-wide packer with a single prefetch-style output holding register.
// Narrow words fill lanes in ascending order; a full group or a flush moves the
// accumulated lanes into the holding register, which is presented until accepted.
module pack_16i_256o_prefetch #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 256
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [IN_WIDTH-1:0]                       in_data,
  input  logic                                      in_vld,
  output logic                                      in_rdy,
  input  logic                                      flush,
  output logic [OUT_WIDTH-1:0]                      out_data,
  output logic [$clog2(OUT_WIDTH/IN_WIDTH):0]       out_words,
  output logic                                      out_vld,
  input  logic                                      out_en
);

  // N is the lane count and must be a power of two between 2 and 64.
  localparam int N  = OUT_WIDTH / IN_WIDTH;
  localparam int CW = $clog2(N);
  localparam int WW = CW + 1;
  localparam logic [CW-1:0] LAST_LANE = CW'(N - 1);

  logic [OUT_WIDTH-1:0] acc;
  logic [OUT_WIDTH-1:0] acc_next;
  logic [CW-1:0]        cnt;
  logic                 flush_pend;
  logic                 rdy_en;
  logic                 accept;
  logic                 hold_free;
  logic                 full_word;
  logic                 flush_req;
  logic [WW-1:0]        fill_words;

  // Ready depends only on registered state so out_en and in_vld never reach in_rdy.
  // rdy_en keeps in_rdy low during reset and raises it on the first edge after.
  assign in_rdy     = rdy_en && !flush_pend && !((cnt == LAST_LANE) && out_vld);
  assign accept     = in_vld && in_rdy;
  assign hold_free  = !out_vld || out_en;
  assign full_word  = accept && (cnt == LAST_LANE);
  assign flush_req  = flush && !flush_pend && ((cnt != '0) || accept);
  assign fill_words = WW'(cnt) + WW'(accept);

  // Accumulator view including the word accepted this cycle, placed at lane cnt.
  always_comb begin
    acc_next = acc;
    for (int k = 0; k < N; k++) begin
      if (accept && (cnt == CW'(k))) begin
        acc_next[k*IN_WIDTH +: IN_WIDTH] = in_data;
      end
    end
  end

  // Lane counting, holding-register loads (full group, flush, deferred flush) and output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      cnt        <= '0;
      flush_pend <= 1'b0;
      rdy_en     <= 1'b0;
      out_data   <= '0;
      out_words  <= '0;
      out_vld    <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (out_vld && out_en) begin
        out_vld <= 1'b0;
      end
      if (flush_pend) begin
        if (hold_free) begin
          out_data   <= acc;
          out_words  <= WW'(cnt);
          out_vld    <= 1'b1;
          acc        <= '0;
          cnt        <= '0;
          flush_pend <= 1'b0;
        end
      end else if (full_word || (flush_req && hold_free)) begin
        out_data  <= acc_next;
        out_words <= fill_words;
        out_vld   <= 1'b1;
        acc       <= '0;
        cnt       <= '0;
      end else begin
        acc <= acc_next;
        cnt <= cnt + CW'(accept);
        if (flush_req) begin
          flush_pend <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pack_16i_256o_prefetch.sv
// Directed self-checking bench for pack_16i_256o_prefetch with default parameters.
module tb_pack_16i_256o_prefetch;

  logic         clk;
  logic         rst_n;
  logic [15:0]  in_data;
  logic         in_vld;
  logic         in_rdy;
  logic         flush;
  logic [255:0] out_data;
  logic [4:0]   out_words;
  logic         out_vld;
  logic         out_en;

  int compare_count;
  int mismatch_count;
  int stalls;
  int total_stalls;

  pack_16i_256o_prefetch #(.IN_WIDTH(16), .OUT_WIDTH(256)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_vld    (in_vld),
    .in_rdy    (in_rdy),
    .flush     (flush),
    .out_data  (out_data),
    .out_words (out_words),
    .out_vld   (out_vld),
    .out_en    (out_en)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected wide word whose first n lanes hold base, base+1, ... and the rest zero.
  function automatic logic [255:0] make_group(input logic [15:0] base, input int n);
    logic [255:0] v;
    v = '0;
    for (int k = 0; k < n; k++) v[k*16 +: 16] = base + 16'(k);
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    compare_count++;
    if (obs !== exp) begin
      mismatch_count++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer one word (optionally with flush) until accepted; returns cycles spent stalled.
  task automatic applyStimulus(input logic [15:0] d, input logic fl, output int stall_cnt);
    stall_cnt = 0;
    in_data = d;
    in_vld  = 1'b1;
    flush   = fl;
    while (!in_rdy && stall_cnt < 50) begin
      @(posedge clk);
      #1;
      stall_cnt++;
    end
    if (!in_rdy) begin
      checkOutput("accept_timeout", 0, 1);
    end else begin
      @(posedge clk);
      #1;
    end
    in_vld = 1'b0;
    flush  = 1'b0;
  endtask

  initial begin
    compare_count  = 0;
    mismatch_count = 0;
    rst_n   = 1'b0;
    in_data = '0;
    in_vld  = 1'b0;
    flush   = 1'b0;
    out_en  = 1'b0;
    idle(3);

    // Reset state
    checkOutput("rst_in_rdy", in_rdy, 0);
    checkOutput("rst_out_vld", out_vld, 0);
    checkOutput("rst_out_words", out_words, 0);
    checkOutput("rst_out_data", out_data, 0);
    rst_n = 1'b1;
    #1;
    checkOutput("rdy_before_edge", in_rdy, 0);
    @(posedge clk);
    #1;
    checkOutput("rdy_after_edge", in_rdy, 1);

    // 16 words 0..15, out_en high
    out_en = 1'b1;
    for (int i = 0; i < 16; i++) applyStimulus(16'(i), 1'b0, stalls);
    checkOutput("g0_vld", out_vld, 1);
    checkOutput("g0_words", out_words, 16);
    checkOutput("g0_data", out_data, make_group(16'h0000, 16));
    idle(1);
    checkOutput("g0_drained", out_vld, 0);

    // 32 continuous words, never stalled
    total_stalls = 0;
    for (int i = 0; i < 32; i++) begin
      applyStimulus((i < 16) ? 16'(16'h0100 + i) : 16'(16'h0200 + i - 16), 1'b0, stalls);
      total_stalls += stalls;
      if (i == 15) begin
        checkOutput("c1_vld", out_vld, 1);
        checkOutput("c1_data", out_data, make_group(16'h0100, 16));
      end
      if (i == 31) begin
        checkOutput("c2_vld", out_vld, 1);
        checkOutput("c2_data", out_data, make_group(16'h0200, 16));
      end
    end
    checkOutput("cont_no_stall", total_stalls, 0);
    idle(1);

    // Back-pressure: out_en low, 31 words fit, the 32nd waits
    out_en = 1'b0;
    total_stalls = 0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(16'(16'h0300 + i), 1'b0, stalls);
      total_stalls += stalls;
    end
    for (int i = 0; i < 15; i++) begin
      applyStimulus(16'(16'h0400 + i), 1'b0, stalls);
      total_stalls += stalls;
    end
    checkOutput("bp_no_stall", total_stalls, 0);
    checkOutput("bp_rdy_low", in_rdy, 0);
    checkOutput("bp_vld", out_vld, 1);
    checkOutput("bp_held", out_data, make_group(16'h0300, 16));
    in_data = 16'h040F;
    in_vld  = 1'b1;
    idle(2);
    checkOutput("bp_rdy_still_low", in_rdy, 0);
    checkOutput("bp_held_stable", out_data, make_group(16'h0300, 16));
    out_en = 1'b1;
    @(posedge clk);
    #1;
    out_en = 1'b0;
    checkOutput("bp_freed_vld", out_vld, 0);
    checkOutput("bp_freed_rdy", in_rdy, 1);
    @(posedge clk);
    #1;
    in_vld = 1'b0;
    checkOutput("bp_second_vld", out_vld, 1);
    checkOutput("bp_second_words", out_words, 16);
    checkOutput("bp_second_data", out_data, make_group(16'h0400, 16));
    out_en = 1'b1;
    idle(1);
    checkOutput("bp_drained", out_vld, 0);

    // Partial flush of 3 words
    for (int i = 0; i < 3; i++) applyStimulus(16'(16'h00A1 + i), 1'b0, stalls);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checkOutput("fl3_vld", out_vld, 1);
    checkOutput("fl3_words", out_words, 3);
    checkOutput("fl3_data", out_data, make_group(16'h00A1, 3));
    idle(1);
    // Flush with nothing buffered does nothing
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checkOutput("fl_empty_vld", out_vld, 0);
    // Flush together with a single accepted word
    applyStimulus(16'h00B1, 1'b1, stalls);
    checkOutput("fl1_words", out_words, 1);
    checkOutput("fl1_data", out_data, make_group(16'h00B1, 1));
    idle(1);
    // Flush on the 16th word is a full emission
    for (int i = 0; i < 15; i++) applyStimulus(16'(16'h0800 + i), 1'b0, stalls);
    applyStimulus(16'h080F, 1'b1, stalls);
    checkOutput("fl16_words", out_words, 16);
    checkOutput("fl16_data", out_data, make_group(16'h0800, 16));
    idle(1);

    // Flush while the holding register is occupied
    out_en = 1'b0;
    for (int i = 0; i < 16; i++) applyStimulus(16'(16'h0500 + i), 1'b0, stalls);
    applyStimulus(16'h0601, 1'b0, stalls);
    applyStimulus(16'h0602, 1'b0, stalls);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checkOutput("pend_rdy_low", in_rdy, 0);
    checkOutput("pend_held", out_data, make_group(16'h0500, 16));
    idle(2);
    checkOutput("pend_rdy_still_low", in_rdy, 0);
    out_en = 1'b1;
    @(posedge clk);
    #1;
    out_en = 1'b0;
    checkOutput("pend_emit_vld", out_vld, 1);
    checkOutput("pend_emit_words", out_words, 2);
    checkOutput("pend_emit_data", out_data, make_group(16'h0601, 2));
    checkOutput("pend_rdy_back", in_rdy, 1);
    out_en = 1'b1;
    idle(1);
    checkOutput("pend_drained", out_vld, 0);

    // Reset mid-group discards the partial data
    for (int i = 0; i < 7; i++) applyStimulus(16'(16'h0900 + i), 1'b0, stalls);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_vld", out_vld, 0);
    checkOutput("mid_rst_rdy", in_rdy, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("mid_rst_rdy_back", in_rdy, 1);
    checkOutput("mid_rst_no_emit", out_vld, 0);
    for (int i = 0; i < 16; i++) applyStimulus(16'(16'h0700 + i), 1'b0, stalls);
    checkOutput("post_rst_words", out_words, 16);
    checkOutput("post_rst_data", out_data, make_group(16'h0700, 16));
    idle(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
